// File: rtl/deskew_if.sv
// Handshake/bus bundle between the accelerator controller, the systolic
// array output and the de-skew write-back block.
//   master: drives start/base_addr/num_rows/in_valid/data_in, observes the
//           SRAM write port (wen_n/waddr/wdata) and busy/done.
//   slave : the de-skew block side.
interface deskew_if #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int RW = 8
);
    logic                   start;
    logic [AW-1:0]          base_addr;
    logic [RW-1:0]          num_rows;
    logic                   in_valid;
    logic [N-1:0][DW-1:0]   data_in;
    logic                   wen_n;
    logic [AW-1:0]          waddr;
    logic [N-1:0][DW-1:0]   wdata;
    logic                   busy;
    logic                   done;

    modport master (
        output start, base_addr, num_rows, in_valid, data_in,
        input  wen_n, waddr, wdata, busy, done
    );

    modport slave (
        input  start, base_addr, num_rows, in_valid, data_in,
        output wen_n, waddr, wdata, busy, done
    );
endinterface

// File: rtl/deskew_array.sv
// Re-aligns staggered systolic-array result columns into row words and
// writes them to SRAM with an auto-incrementing address.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : deskew_if.slave (start/base_addr/num_rows control,
//                in_valid/data_in skewed columns, wen_n/waddr/wdata
//                SRAM write port, busy/done status)
module deskew_array #(
    parameter int N  = 8,
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int RW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    deskew_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_n;
    logic [N-1:0][DW-1:0] aligned;
    logic [N-2:0]         vsr;
    logic                 aligned_valid;
    logic [AW-1:0]        base_q;
    logic [RW-1:0]        num_q;
    logic [RW-1:0]        row_cnt;
    logic                 wr_fire;

    // Column j is late by j cycles, so it gets N-1-j stages of delay.
    for (genvar j = 0; j < N-1; j++) begin : g_col
        localparam int L = N-1-j;
        logic [DW-1:0] sr [L];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < L; k++) sr[k] <= '0;
            end else begin
                sr[0] <= bus.data_in[j];
                for (int k = 1; k < L; k++) sr[k] <= sr[k-1];
            end
        end
        assign aligned[j] = sr[L-1];
    end
    assign aligned[N-1] = bus.data_in[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr <= '0;
        end else begin
            vsr[0] <= bus.in_valid;
            for (int k = 1; k < N-1; k++) vsr[k] <= vsr[k-1];
        end
    end
    assign aligned_valid = vsr[N-2];

    // Rows arriving once the count is exhausted are dropped.
    assign wr_fire = (state == RUN) && aligned_valid && (row_cnt != num_q);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_n = (bus.num_rows == '0) ? DONE : RUN;
            end
            RUN: begin
                if (row_cnt == num_q) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            num_q     <= '0;
            row_cnt   <= '0;
            bus.wen_n <= 1'b1;
            bus.waddr <= '0;
            bus.wdata <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            state     <= state_n;
            bus.busy  <= (state_n == RUN);
            bus.done  <= (state_n == DONE);
            bus.wen_n <= !wr_fire;
            if (state == IDLE && bus.start) begin
                base_q  <= bus.base_addr;
                num_q   <= bus.num_rows;
                row_cnt <= '0;
            end
            if (wr_fire) begin
                bus.waddr <= base_q + AW'(row_cnt);
                bus.wdata <= aligned;
                row_cnt   <= row_cnt + RW'(1);
            end
        end
    end
endmodule

// File: tb/tb_deskew_array.sv
// Scoreboard bench for deskew_array: directed bursts plus random bursts
// checked against a row-level reference model.
module tb_deskew_array;
    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int RW = 8;

    typedef logic [N-1:0][DW-1:0] row_t;
    typedef struct {
        int        cyc;
        logic [AW-1:0] addr;
        row_t      data;
    } wr_t;
    typedef struct {
        logic v;
        row_t d;
    } samp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    deskew_if #(.N(N), .DW(DW), .AW(AW), .RW(RW)) bus ();

    deskew_array #(.N(N), .DW(DW), .AW(AW), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;

    wr_t   sb [$];
    samp_t hist [$];
    logic  exp_busy = 1'b0;
    logic  exp_done = 1'b0;
    int    mst = 0;
    int    mb, mn, mc;

    // Reference model: a row becomes visible once its last column has
    // arrived (N-1 cycles after in_valid) and is written the cycle after.
    always @(posedge clk or negedge rst_n) begin : model
        samp_t s;
        row_t  word;
        logic  av;
        int    nxt;
        if (!rst_n) begin
            mst = 0;
            sb.delete();
            hist.delete();
            exp_busy = 1'b0;
            exp_done = 1'b0;
            s.v = 1'b0;
            s.d = '0;
            for (int i = 0; i < N; i++) hist.push_back(s);
        end else begin
            s.v = bus.in_valid;
            s.d = bus.data_in;
            hist.push_front(s);
            void'(hist.pop_back());
            av = hist[N-1].v;
            for (int j = 0; j < N; j++) word[j] = hist[N-1-j].d[j];
            nxt = mst;
            case (mst)
                0: if (bus.start) begin
                    mb = int'(bus.base_addr);
                    mn = int'(bus.num_rows);
                    mc = 0;
                    nxt = (mn == 0) ? 2 : 1;
                end
                1: if (mc == mn) nxt = 2;
                   else if (av) begin
                    sb.push_back('{cyc + 1,
                        AW'((mb + mc) % (1 << AW)), word});
                    mc++;
                end
                default: nxt = 0;
            endcase
            mst = nxt;
            exp_busy = (nxt == 1);
            exp_done = (nxt == 2);
        end
    end

    logic [AW-1:0] hold_a = '0;
    row_t          hold_d = '0;

    always @(negedge clk) begin : monitor
        logic exp_w;
        wr_t  e;
        cyc++;
        if (!rst_n) begin
            hold_a = '0;
            hold_d = '0;
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++; errors++;
            $display("FAIL missed_write cyc=%0d addr=%h", e.cyc, e.addr);
        end
        exp_w = (sb.size() > 0) && (sb[0].cyc == cyc);
        checks++;
        if ((bus.wen_n == 1'b0) != exp_w) begin
            errors++;
            $display("FAIL wen_n cyc=%0d got=%b exp=%b",
                     cyc, bus.wen_n, !exp_w);
        end else if (exp_w) begin
            e = sb.pop_front();
            wr_cnt++;
            checks++;
            if (bus.waddr !== e.addr || bus.wdata !== e.data) begin
                errors++;
                $display("FAIL write cyc=%0d got=%h/%h exp=%h/%h",
                         cyc, bus.waddr, bus.wdata, e.addr, e.data);
            end
            hold_a = e.addr;
            hold_d = e.data;
        end else begin
            checks++;
            if (bus.waddr !== hold_a || bus.wdata !== hold_d) begin
                errors++;
                $display("FAIL hold cyc=%0d got=%h/%h exp=%h/%h",
                         cyc, bus.waddr, bus.wdata, hold_a, hold_d);
            end
        end
        checks++;
        if (bus.busy !== exp_busy || bus.done !== exp_done) begin
            errors++;
            $display("FAIL status cyc=%0d busy/done got=%b%b exp=%b%b",
                     cyc, bus.busy, bus.done, exp_busy, exp_done);
        end
    end

    row_t rh [N];

    task automatic step(input bit v, input row_t row, input bit st,
                        input logic [AW-1:0] b, input logic [RW-1:0] nr);
        @(negedge clk);
        for (int j = N-1; j > 0; j--) rh[j] = rh[j-1];
        rh[0] = row;
        for (int j = 0; j < N; j++) bus.data_in[j] = rh[j][j];
        bus.in_valid  = v;
        bus.start     = st;
        bus.base_addr = b;
        bus.num_rows  = nr;
    endtask

    function automatic row_t rnd_row();
        row_t r;
        for (int j = 0; j < N; j++) r[j] = DW'($urandom);
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, rnd_row(), 1'b0, AW'($urandom), RW'($urandom));
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [RW-1:0] nr);
        step(1'b0, rnd_row(), 1'b1, b, nr);
    endtask

    task automatic feed(input row_t r);
        step(1'b1, r, 1'b0, AW'($urandom), RW'($urandom));
    endtask

    task automatic chk_reset(input string tag);
        checks++;
        if (bus.wen_n !== 1'b1 || bus.waddr !== '0 || bus.wdata !== '0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s got wen_n=%b waddr=%h busy=%b done=%b exp 1/0/0/0",
                     tag, bus.wen_n, bus.waddr, bus.busy, bus.done);
        end
    endtask

    initial begin
        row_t r;
        int   target;
        int   t;
        for (int j = 0; j < N; j++) rh[j] = '0;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_rows = '0;
        bus.in_valid = 1'b0;
        bus.data_in = '0;
        #23;
        chk_reset("reset_values");
        rst_n = 1'b1;
        idle(2);

        // single row, columns 1..8
        go(AW'('h010), RW'(1));
        for (int j = 0; j < N; j++) r[j] = DW'(j + 1);
        feed(r);
        idle(12);

        // four rows back to back
        go(AW'('h010), RW'(4));
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < N; j++) r[j] = DW'(16 * k + j);
            feed(r);
        end
        idle(12);

        // zero-row burst
        go(AW'('h055), RW'(0));
        idle(4);

        // valid rows in IDLE, then a second start during RUN
        for (int k = 0; k < 3; k++) feed(rnd_row());
        idle(10);
        go(AW'('h020), RW'(3));
        feed(rnd_row());
        step(1'b1, rnd_row(), 1'b1, AW'('h300), RW'(7));
        feed(rnd_row());
        idle(12);

        // address wrap
        go(AW'('h3FE), RW'(3));
        for (int k = 0; k < 3; k++) feed(rnd_row());
        idle(12);

        // reset after two of five writes
        target = wr_cnt + 2;
        go(AW'('h0A0), RW'(5));
        for (int k = 0; k < 5; k++) feed(rnd_row());
        t = 0;
        while (wr_cnt < target && t < 60) begin
            idle(1);
            t++;
        end
        checks++;
        if (wr_cnt < target) begin
            errors++;
            $display("FAIL reset_wait writes=%0d exp>=%0d", wr_cnt, target);
        end
        #1 rst_n = 1'b0;
        #1 chk_reset("mid_burst_reset");
        idle(3);
        #1 rst_n = 1'b1;
        idle(10);
        go(AW'('h100), RW'(2));
        feed(rnd_row());
        feed(rnd_row());
        idle(12);

        // random bursts
        for (int b = 0; b < 20; b++) begin
            int nr;
            nr = $urandom_range(0, 6);
            go(AW'($urandom), RW'(nr));
            for (int k = 0; k < nr + $urandom_range(0, 1); k++) begin
                if ($urandom_range(0, 2) == 0) idle(1);
                if ($urandom_range(0, 5) == 0)
                    step(1'b1, rnd_row(), 1'b1, AW'($urandom), RW'($urandom));
                else
                    feed(rnd_row());
            end
            idle(12);
        end

        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_writes got=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/deskew_array.md
Name: deskew_array

Overview:
- Output-side counterpart of the systolic-array input skew stage.
- The systolic array emits result columns staggered in time: column j of a row arrives j cycles after column 0.
- This block re-aligns the N columns into one word per row and writes each aligned row back to SRAM through an active-low write strobe with an auto-incrementing address.
- A start/busy/done control FSM, driven by the accelerator controller, frames each write-back burst.

Parameters:
- N, 8, number of array columns (N >= 2).
- DW, 8, width of one column element in bits.
- AW, 10, SRAM word address width.
- RW, 8, width of the row-count field.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a burst; sampled only in IDLE.
- base_addr  input  AW  first SRAM address of the burst; latched on start.
- num_rows  input  RW  number of rows to write; latched on start.
- in_valid  input  1  high in the cycle column 0 of a row is valid; column j is implicitly valid j cycles later.
- data_in  input  [N-1:0][DW-1:0]  skewed column data from the array.
- wen_n  output  1  active-low SRAM write enable.
- waddr  output  AW  SRAM write address.
- wdata  output  [N-1:0][DW-1:0]  aligned row word.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
Reset and register outputs:
- Reset is asynchronous, active-low.
- Reset clears all delay registers, the valid pipeline and the FSM.
- Reset values: wen_n=1, waddr=0, wdata=0, busy=0, done=0.
- All outputs are registered.

De-skew datapath:
- Column j passes through a delay line of N-1-j stages; column N-1 has zero stages.
- Delay lines shift every cycle, independent of FSM state.
- in_valid passes through a separate N-1-stage delay line, producing aligned_valid.
- Row sampled at cycle t (in_valid=1): aligned at cycle t+N-1, presented on wdata/waddr with wen_n=0 at cycle t+N.
- Row throughput is 1 per cycle; back-to-back in_valid is supported with no bubbles.

FSM:
- IDLE:
  - start latches base_addr and num_rows, clears row_cnt.
  - Goes to RUN; if num_rows==0, goes to DONE instead.
  - aligned_valid is ignored and wen_n stays 1.
- RUN:
  - busy=1.
  - On each aligned_valid: next cycle wen_n=0, wdata=aligned word, waddr=base+row_cnt (mod 2^AW, wraps silently); row_cnt increments.
  - When the write of row num_rows-1 is issued, go to DONE.
  - start is ignored in RUN.
  - aligned_valid with no remaining rows is dropped.
- DONE:
  - done=1 for exactly one cycle, then IDLE; busy=0.
  - A start arriving in DONE is ignored.

Other rules:
- wen_n is 1 in every cycle without a write; wdata/waddr hold their last written values when idle.
- Reset asserted mid-burst aborts immediately: no further writes, done is not pulsed, and rows in flight are discarded.

Test Plan:
- N=8, DW=8: start with base=0x010 and num_rows=1; at cycle t assert in_valid, then drive column j=j+1 at cycle t+j. -> Single wen_n=0 at t+8, waddr=0x010, wdata columns = {1..8}; done pulses at t+9; busy falls with done.
- num_rows=4, rows fed back-to-back (column 0 valid at t..t+3, each column value = 0x10*row+col). -> wen_n low for cycles t+8..t+11, waddr 0x010..0x013, each wdata row correctly aligned, exactly one done.
- Start with num_rows=0. -> No write; done pulses 1 cycle after start; busy never rises.
- in_valid driven while IDLE, plus a second start during RUN. -> No writes occur in IDLE; the second start has no effect on address or count.
- base=0x3FE, num_rows=3. -> waddr sequence 0x3FE, 0x3FF, 0x000.
- rst_n pulled low after 2 of 5 rows are written. -> Outputs immediately at reset values, no further wen_n=0, no done; a new start after reset behaves normally.
